// File: rtl/kernel_distribution_sequencer_if.sv
// Bundle of the handshake, config and kernel-buffer signals around the kernel
// distribution sequencer.
//   master : drives start/cfgTrc/cfgLen/opReady and observes the sequencer outputs
//   slave  : the sequencer itself
// Signals:
//   start    one-cycle pass request
//   cfgTrc   group size minus 1 (depth bits)
//   cfgLen   kernel addresses per bank (AW bits)
//   kbRdEn   kernel buffer read enable
//   kbAddr   kernel buffer read address
//   distCtrl {Trc, bankSelect} distributor control word
//   opValid  distributor beat valid
//   opReady  downstream accepts the beat
//   busy     sequencer is not idle
//   done     one-cycle end-of-pass pulse
interface kernel_distribution_sequencer_if #(
  parameter int unsigned depth = 2,
  parameter int unsigned AW    = 8
);
  logic               start;
  logic [depth-1:0]   cfgTrc;
  logic [AW-1:0]      cfgLen;
  logic               kbRdEn;
  logic [AW-1:0]      kbAddr;
  logic [2*depth-1:0] distCtrl;
  logic               opValid;
  logic               opReady;
  logic               busy;
  logic               done;

  modport master (
    output start, cfgTrc, cfgLen, opReady,
    input  kbRdEn, kbAddr, distCtrl, opValid, busy, done
  );

  modport slave (
    input  start, cfgTrc, cfgLen, opReady,
    output kbRdEn, kbAddr, distCtrl, opValid, busy, done
  );
endinterface

// File: rtl/kernel_distribution_sequencer.sv
// Kernel distribution sequencer: for one kernel-load pass, walks every kernel
// address (outer loop) and every bank of the selected group (inner loop),
// issuing kernel buffer reads and presenting the matching {Trc, bankSelect}
// control word one cycle later, aligned with the returned read data.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of kernel_distribution_sequencer_if (config, kernel
//          buffer read port, distributor valid/ready output, busy/done)
module kernel_distribution_sequencer #(
  parameter int unsigned depth = 2,
  parameter int unsigned D     = 1 << depth,
  parameter int unsigned AW    = 8
) (
  input logic                             clk,
  input logic                             reset,
  kernel_distribution_sequencer_if.slave  bus
);

  // Bank index only ever needs to cover the D physical banks.
  localparam int unsigned BankW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [depth-1:0]   trc_q, trc_d;
  logic [AW-1:0]      len_q, len_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic               opvalid_q;
  logic [2*depth-1:0] distctrl_q;

  logic adv;
  logic rd_en;
  logic bank_wrap;
  logic last_issue;

  always_comb begin
    state_d = state_q;
    trc_d   = trc_q;
    len_d   = len_q;
    addr_d  = addr_q;
    bank_d  = bank_q;

    // The output stage can take a new beat when empty or being drained.
    adv        = !opvalid_q || bus.opReady;
    rd_en      = (state_q == StRun) && adv;
    bank_wrap  = (depth'(bank_q) == trc_q);
    // len_q is never 0 in StRun, so len_q - 1 cannot wrap here.
    last_issue = rd_en && bank_wrap && (addr_q == len_q - AW'(1));

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          trc_d   = bus.cfgTrc;
          len_d   = bus.cfgLen;
          addr_d  = '0;
          bank_d  = '0;
          state_d = (bus.cfgLen == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (rd_en) begin
          if (bank_wrap) begin
            bank_d = '0;
            addr_d = addr_q + AW'(1);
          end else begin
            bank_d = bank_q + BankW'(1);
          end
          if (last_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (adv) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      trc_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      trc_q   <= trc_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
    end
  end

  // Output stage: control word uses the pre-increment bank so it lines up
  // with the data returned for the read issued in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opvalid_q  <= 1'b0;
      distctrl_q <= '0;
    end else if (adv) begin
      opvalid_q  <= rd_en;
      distctrl_q <= {trc_q, depth'(bank_q)};
    end
  end

  assign bus.kbRdEn   = rd_en;
  assign bus.kbAddr   = addr_q;
  assign bus.distCtrl = distctrl_q;
  assign bus.opValid  = opvalid_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);

endmodule

// File: doc/kernel_distribution_sequencer.md
# kernel_distribution_sequencer

Sequences kernel-buffer reads and the distributor control word for one kernel-load pass. For each kernel address it walks the banks of the selected group size. It issues a read to the kernel buffer and presents the matching `{Trc, bankSelect}` control word, aligned with the returned data, to the kernel buffer distributor. Downstream consumption is paced by a valid/ready handshake.

## Interface
Parameters:
- `depth`, 2: log2 of bank count.
- `D`, `1<<depth`: number of kernel buffer banks / distributor rows.
- `AW`, 8: kernel buffer address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `cfgTrc`  in  depth  group size minus 1; sampled on accepted `start`.
- `cfgLen`  in  AW  number of kernel addresses per bank; sampled on accepted `start`.
- `kbRdEn`  out  1  kernel buffer read enable.
- `kbAddr`  out  AW  kernel buffer read address.
- `distCtrl`  out  2*depth  distributor control word `{Trc, bankSelect}`; `Trc` is in the upper `depth` bits.
- `opValid`  out  1  distributor output beat valid.
- `opReady`  in  1  downstream accepts the beat.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE:
    - `start` goes to RUN. Latch `trcR=cfgTrc` and `lenR=cfgLen`. Clear `addr=0` and `bank=0`.
    - If `cfgLen==0`, go directly to DONE.
  - RUN: issue beats. After the final issue, go to DRAIN.
  - DRAIN: wait until the final beat is accepted (`!opValid || opReady`), then go to DONE.
  - DONE: assert `done`, then return to IDLE.
- Beat order:
  - Inner loop: `bank` runs 0..`trcR`. Outer loop: `addr` runs 0..`lenR-1`.
  - Total beats per pass: `lenR*(trcR+1)`.
- Advance condition: `adv = !opValid || opReady`.
- `kbRdEn = (state==RUN) && adv`. This is combinational. `kbAddr = addr`, a register.
- On each issue (`kbRdEn`):
  - If `bank==trcR`: set `bank=0` and `addr=addr+1`.
  - Otherwise: `bank=bank+1`.
  - Last issue is when `bank==trcR` and `addr==lenR-1`. RUN goes to DRAIN on that edge. Compare `addr` against `lenR-1` without wrap; `lenR==0` never reaches RUN.
- Output stage, registered:
  - When `adv`: `opValid <= kbRdEn` and `distCtrl <= {trcR, bank}` using the pre-increment `bank`.
  - Otherwise `opValid` and `distCtrl` hold.
- The kernel buffer has 1-cycle read latency and holds its read data while `kbRdEn` is low. That lets the distributor data stay stable under backpressure.
- `bank` never exceeds `trcR`, so `bankSelect <= Trc` always holds at the distributor.
- `start` outside IDLE is ignored, and config is not re-sampled.
- Reset, asynchronous and honoured at any point including mid-pass:
  - State goes to IDLE.
  - `addr=0`, `bank=0`, `trcR=0`, `lenR=0`.
  - `opValid=0`, `distCtrl=0`, `done=0`, `busy=0`, `kbRdEn=0`, `kbAddr=0`.
  - Any in-flight beat is dropped.

## Timing
- `start` sampled at edge E0. RUN is active from E0. The first `kbRdEn` occurs in the cycle after E0, with `kbAddr=0`.
- Issue-to-valid latency is 1 cycle. `distCtrl` changes only on the same edge that `opValid` is updated.
- With `opReady` held high, throughput is 1 beat/cycle. A pass of N beats:
  - `opValid` is high for N consecutive cycles.
  - `done` pulses 1 cycle after the last valid cycle.
  - `busy` is high from the cycle after `start` through the `done` cycle inclusive.
- `opReady` low while `opValid` is high:
  - `kbRdEn=0`; `addr` and `bank` freeze.
  - `opValid` and `distCtrl` hold.
  - No beat is lost or duplicated.
- `cfgLen==0`: `busy` is high for 1 cycle (DONE) with `done` high in that same cycle. No `kbRdEn` and no `opValid`.
- `done` and a new `start` in the same cycle: `start` is ignored because the state is not IDLE. A new `start` is accepted from the next cycle.

## Test plan
- `cfgTrc=1`, `cfgLen=3`, `opReady=1`:
  - `kbAddr` sequence is 0,0,1,1,2,2.
  - `distCtrl` sequence (`{Trc,bankSelect}`, depth=2) is 4,5,4,5,4,5 on 6 consecutive `opValid` cycles.
  - `done` pulses on the cycle after the 6th beat.
- `cfgTrc=3`, `cfgLen=2`, `opReady` toggling 1,0,0,1,...:
  - 8 beats with `bankSelect` 0,1,2,3,0,1,2,3.
  - `distCtrl` is held stable during every stall.
  - `kbRdEn` is 0 whenever `opValid&&!opReady`.
- `cfgTrc=0`, `cfgLen=4`: 4 beats, all with `distCtrl=0`, and `kbAddr` sequence 0,1,2,3.
- `cfgLen=0`: `busy` and `done` are high for exactly 1 cycle; `kbRdEn` and `opValid` never assert.
- `start` pulsed again mid-pass with different config: it is ignored, and the original beat count and config complete unchanged.
- `reset` asserted mid-pass, after the 3rd beat:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, a new `start` runs a full, correct pass from `addr=0`.
